// File: rtl/rf_core.sv
`default_nettype none
// ============================================================================
// Module   : rf_core
// Purpose  : 32-entry register bank, base+offset adder and word-addressed RAM.
//            Optional macro RF_ZERO_REG_EN hard-wires R[0] to zero.
// Revision : 1.0
// ============================================================================
module rf_core #(
  parameter int DATA_W = 64,
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [4:0]        a,
  input  logic [4:0]        b,
  input  logic [DATA_W-1:0] din,
  input  logic              load_store,
  input  logic [4:0]        w,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb
);

  localparam int NUM_REGS  = 32;
  localparam int MEM_WORDS = 2**MEM_AW;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] mem_q  [MEM_WORDS];
  logic [DATA_W-1:0] mem_d  [MEM_WORDS];
  logic [DATA_W-1:0] addr_sum;
  logic [MEM_AW-1:0] mem_idx;
  logic              unused_addr_hi;

  // Carry out of the sum is dropped and only the low bits index the RAM,
  // so addresses wrap modulo the memory size.
  assign addr_sum       = din + regs_q[b];
  assign mem_idx        = addr_sum[MEM_AW-1:0];
  assign unused_addr_hi = ^addr_sum[DATA_W-1:MEM_AW];

`ifdef RF_ZERO_REG_EN
  assign douta = (a == 5'd0) ? '0 : regs_q[a];
  assign doutb = (b == 5'd0) ? '0 : regs_q[b];
`else
  assign douta = regs_q[a];
  assign doutb = regs_q[b];
`endif

  always_comb begin
    regs_d = regs_q;
    mem_d  = mem_q;
    if (enable) begin
      if (load_store) begin
`ifdef RF_ZERO_REG_EN
        if (w != 5'd0) begin
          regs_d[w] = mem_q[mem_idx];
        end
`else
        regs_d[w] = mem_q[mem_idx];
`endif
      end else begin
        mem_d[mem_idx] = regs_q[a];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
      for (int j = 0; j < MEM_WORDS; j++) begin
        mem_q[j] <= DATA_W'(j);
      end
    end else begin
      regs_q <= regs_d;
      mem_q  <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_core
// Purpose  : Directed self-checking bench for rf_core.
// Revision : 1.0
// ============================================================================
module tb_rf_core;

  localparam int DATA_W = 64;
  localparam int MEM_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [4:0]        a;
  logic [4:0]        b;
  logic [DATA_W-1:0] din;
  logic              load_store;
  logic [4:0]        w;
  logic [DATA_W-1:0] douta;
  logic [DATA_W-1:0] doutb;

  int vectors     = 0;
  int miscompares = 0;

  rf_core #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .a         (a),
    .b         (b),
    .din       (din),
    .load_store(load_store),
    .w         (w),
    .douta     (douta),
    .doutb     (doutb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [DATA_W-1:0] off, input logic [4:0] base, input logic [4:0] dst);
    enable = 1'b1; load_store = 1'b1; din = off; b = base; w = dst;
    tick();
    enable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; load_store = 1'b0; din = '0; a = '0; b = '0; w = '0;
    tick();
    rst_n = 1'b1;
    a = 5'd2; b = 5'd3; #1;
    vectors++; if (douta !== 64'd2)  begin miscompares++; $display("FAIL reset_a2 got %0d want 2", douta); end
    vectors++; if (doutb !== 64'd3)  begin miscompares++; $display("FAIL reset_b3 got %0d want 3", doutb); end
    a = 5'd30; b = 5'd31; #1;
    vectors++; if (douta !== 64'd30) begin miscompares++; $display("FAIL reset_a30 got %0d want 30", douta); end
    vectors++; if (doutb !== 64'd31) begin miscompares++; $display("FAIL reset_b31 got %0d want 31", doutb); end
  endtask

  task automatic test_store();
    enable = 1'b1; load_store = 1'b0;
    din = 64'd0; a = 5'd2; b = 5'd0; tick();     // M[0] <- 2
    din = 64'd2; a = 5'd4; b = 5'd6; tick();     // M[8] <- 4
    din = 64'd1; a = 5'd11; b = 5'd11; tick();   // M[12] <- 11
    enable = 1'b0;
    a = 5'd2; b = 5'd4; #1;
    vectors++; if (douta !== 64'd2) begin miscompares++; $display("FAIL store_regs_a got %0d want 2", douta); end
    vectors++; if (doutb !== 64'd4) begin miscompares++; $display("FAIL store_regs_b got %0d want 4", doutb); end
  endtask

  task automatic test_load();
    logic [DATA_W-1:0] offs [4];
    logic [4:0]        bases [4];
    logic [4:0]        dsts [4];
    logic [DATA_W-1:0] exps [4];
    offs  = '{64'd3, 64'd10, 64'd0, 64'd0 + 64'd8};
    bases = '{5'd13, 5'd21, 5'd0, 5'd0};
    dsts  = '{5'd2, 5'd3, 5'd30, 5'd31};
    exps  = '{64'd16, 64'd31, 64'd2, 64'd4};
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1; load_store = 1'b1; din = offs[i]; b = bases[i]; w = dsts[i]; a = dsts[i];
      #1;
      vectors++;
      if (douta !== 64'(dsts[i])) begin
        miscompares++; $display("FAIL load_pre_r%0d got %0d want %0d", dsts[i], douta, dsts[i]);
      end
      tick();
      vectors++;
      if (douta !== exps[i]) begin
        miscompares++; $display("FAIL load_post_r%0d got %0d want %0d", dsts[i], douta, exps[i]);
      end
    end
    enable = 1'b0;
    a = 5'd2; b = 5'd3; #1;
    vectors++; if (douta !== 64'd16) begin miscompares++; $display("FAIL load_rd_r2 got %0d want 16", douta); end
    vectors++; if (doutb !== 64'd31) begin miscompares++; $display("FAIL load_rd_r3 got %0d want 31", doutb); end
    a = 5'd30; b = 5'd31; #1;
    vectors++; if (douta !== 64'd2)  begin miscompares++; $display("FAIL load_rd_r30 got %0d want 2", douta); end
    vectors++; if (doutb !== 64'd4)  begin miscompares++; $display("FAIL load_rd_r31 got %0d want 4", doutb); end
    // store with a==b landed at M[12]
    do_load(64'd12, 5'd0, 5'd12);
    a = 5'd12; #1;
    vectors++; if (douta !== 64'd11) begin miscompares++; $display("FAIL store_same_ab got %0d want 11", douta); end
    // w==b: address uses the pre-edge base (14+2=16 -> M[16]=16)
    do_load(64'd2, 5'd14, 5'd14);
    a = 5'd14; #1;
    vectors++; if (douta !== 64'd16) begin miscompares++; $display("FAIL load_w_eq_b got %0d want 16", douta); end
  endtask

  task automatic test_wrap();
    do_load(64'd30, 5'd5, 5'd7);                 // 35 -> index 3
    a = 5'd7; #1;
    vectors++; if (douta !== 64'd3) begin miscompares++; $display("FAIL wrap_idx got %0d want 3", douta); end
    do_load({DATA_W{1'b1}}, 5'd1, 5'd8);         // carry dropped -> M[0]=2
    a = 5'd8; #1;
    vectors++; if (douta !== 64'd2) begin miscompares++; $display("FAIL wrap_carry got %0d want 2", douta); end
  endtask

  task automatic test_enable_low();
    enable = 1'b0; load_store = 1'b1; w = 5'd9; din = 64'd0; b = 5'd0; a = 5'd9;
    repeat (3) tick();
    load_store = 1'bx; w = 5'bx;
    repeat (2) tick();
    load_store = 1'b0; a = 5'd4;                 // disabled store of 4 to M[0]
    repeat (2) tick();
    a = 5'd9; #1;
    vectors++; if (douta !== 64'd9) begin miscompares++; $display("FAIL en_low_r9 got %0d want 9", douta); end
    do_load(64'd0, 5'd0, 5'd10);
    a = 5'd10; #1;
    vectors++; if (douta !== 64'd2) begin miscompares++; $display("FAIL en_low_mem got %0d want 2", douta); end
  endtask

  task automatic test_reset_priority();
    rst_n = 1'b0; enable = 1'b1; load_store = 1'b1; din = 64'd0; b = 5'd0; w = 5'd2;
    tick();
    rst_n = 1'b1; enable = 1'b0;
    a = 5'd2; b = 5'd10; #1;
    vectors++; if (douta !== 64'd2)  begin miscompares++; $display("FAIL rstpri_r2 got %0d want 2", douta); end
    vectors++; if (doutb !== 64'd10) begin miscompares++; $display("FAIL rstpri_r10 got %0d want 10", doutb); end
    do_load(64'd0, 5'd0, 5'd20);
    a = 5'd20; #1;
    vectors++; if (douta !== 64'd0) begin miscompares++; $display("FAIL rstpri_mem0 got %0d want 0", douta); end
  endtask

  task automatic test_zero_reg();
    logic [DATA_W-1:0] exp_r0;
`ifdef RF_ZERO_REG_EN
    exp_r0 = 64'd0;
`else
    exp_r0 = 64'd5;
`endif
    do_load(64'd5, 5'd0, 5'd0);
    a = 5'd0; #1;
    vectors++; if (douta !== exp_r0) begin miscompares++; $display("FAIL zero_reg got %0d want %0d", douta, exp_r0); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wrap();
    test_enable_low();
    test_reset_priority();
    test_zero_reg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
